// File: rtl/gyruss_vid_pkg.sv
// Gyruss video timing constants and beam-position types.
// Shared by the timing generator, the core and the scan converter.
package gyruss_vid_pkg;

  localparam int D_CLK_DIV  = 8;
  localparam int D_H_TOTAL  = 384;
  localparam int D_H_ACTIVE = 256;
  localparam int D_HS_START = 296;
  localparam int D_HS_WIDTH = 32;
  localparam int D_V_TOTAL  = 264;
  localparam int D_VB_END   = 16;
  localparam int D_VB_START = 240;
  localparam int D_VS_START = 248;
  localparam int D_VS_WIDTH = 3;

  typedef logic [8:0] beam_t;
  typedef logic [9:0] spos_t;

  function automatic spos_t sext4(input logic [3:0] v);
    return {{6{v[3]}}, v};
  endfunction

  // Folds a nominal position shifted by at most one
  // period back into 0..tot-1.
  function automatic spos_t wrap_pos(
    input spos_t s,
    input spos_t tot
  );
    spos_t r;
    if (s[9])
      r = s + tot;
    else if (s >= tot)
      r = s - tot;
    else
      r = s;
    return r;
  endfunction

endpackage

// File: rtl/gyruss_win_cmp.sv
// Wrap-aware window compare: is pos inside start..start+width-1
// taken modulo total.
module gyruss_win_cmp
  import gyruss_vid_pkg::*;
(
  input  spos_t i_pos,
  input  spos_t i_start,
  input  spos_t i_width,
  input  spos_t i_total,
  output logic  o_in
);

  spos_t w_diff;
  spos_t w_dist;

  always_comb begin
    w_diff = i_pos - i_start;
    w_dist = w_diff[9] ? w_diff + i_total : w_diff;
    o_in   = (w_dist < i_width);
  end

endmodule

// File: rtl/gyruss_hvgen.sv
// Gyruss pixel strobe, beam counters, blanking and sync.
// Offsets are latched at frame start so centring never tears.
module gyruss_hvgen
  import gyruss_vid_pkg::*;
#(
  parameter int CLK_DIV  = D_CLK_DIV,
  parameter int H_TOTAL  = D_H_TOTAL,
  parameter int H_ACTIVE = D_H_ACTIVE,
  parameter int HS_START = D_HS_START,
  parameter int HS_WIDTH = D_HS_WIDTH,
  parameter int V_TOTAL  = D_V_TOTAL,
  parameter int VB_END   = D_VB_END,
  parameter int VB_START = D_VB_START,
  parameter int VS_START = D_VS_START,
  parameter int VS_WIDTH = D_VS_WIDTH
) (
  input  logic       MCLK,
  input  logic       RESET_N,
  input  logic [3:0] HOFS,
  input  logic [3:0] VOFS,
  output logic       PCLK_EN,
  output beam_t      PH,
  output beam_t      PV,
  output logic       HBLK,
  output logic       VBLK,
  output logic       HSYN,
  output logic       VSYN,
  output logic       VFRM
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam beam_t H_LAST  = beam_t'(H_TOTAL - 1);
  localparam beam_t V_LAST  = beam_t'(V_TOTAL - 1);
  localparam beam_t H_ACT_B = beam_t'(H_ACTIVE);
  localparam beam_t VB_E_B  = beam_t'(VB_END);
  localparam beam_t VB_S_B  = beam_t'(VB_START);
  localparam spos_t H_TOT10 = spos_t'(H_TOTAL);
  localparam spos_t V_TOT10 = spos_t'(V_TOTAL);
  localparam spos_t HS_ST10 = spos_t'(HS_START);
  localparam spos_t VS_ST10 = spos_t'(VS_START);
  localparam spos_t HS_WD10 = spos_t'(HS_WIDTH);
  localparam spos_t VS_WD10 = spos_t'(VS_WIDTH);

  logic [DW-1:0] r_div;
  logic          r_pclk_en;
  beam_t         r_ph;
  beam_t         r_pv;
  logic          r_hblk;
  logic          r_vblk;
  logic          r_hsyn;
  logic          r_vsyn;
  logic          r_vfrm;
  logic [3:0]    r_hofs;
  logic [3:0]    r_vofs;

  logic [DW-1:0] w_div_nx;
  logic          w_h_last;
  logic          w_v_last;
  logic          w_fstart;
  beam_t         w_ph_nx;
  beam_t         w_pv_nx;
  logic [3:0]    w_hofs_nx;
  logic [3:0]    w_vofs_nx;
  spos_t         w_hs0;
  spos_t         w_vs0;
  logic          w_hs_in;
  logic          w_vs_in;

  always_comb begin
    w_div_nx  = (r_div == DIV_LAST) ? '0 : r_div + 1'b1;
    w_h_last  = (r_ph == H_LAST);
    w_v_last  = (r_pv == V_LAST);
    w_fstart  = w_h_last & w_v_last;
    w_ph_nx   = w_h_last ? '0 : r_ph + 1'b1;
    w_pv_nx   = r_pv;
    if (w_h_last)
      w_pv_nx = w_v_last ? '0 : r_pv + 1'b1;
    // New offsets steer the decode of the very first pixel.
    w_hofs_nx = w_fstart ? HOFS : r_hofs;
    w_vofs_nx = w_fstart ? VOFS : r_vofs;
    w_hs0     = wrap_pos(HS_ST10 + sext4(w_hofs_nx), H_TOT10);
    w_vs0     = wrap_pos(VS_ST10 + sext4(w_vofs_nx), V_TOT10);
  end

  gyruss_win_cmp u_hwin (
    .i_pos   ({1'b0, w_ph_nx}),
    .i_start (w_hs0),
    .i_width (HS_WD10),
    .i_total (H_TOT10),
    .o_in    (w_hs_in)
  );

  gyruss_win_cmp u_vwin (
    .i_pos   ({1'b0, w_pv_nx}),
    .i_start (w_vs0),
    .i_width (VS_WD10),
    .i_total (V_TOT10),
    .o_in    (w_vs_in)
  );

  always_ff @(posedge MCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_div     <= '0;
      r_pclk_en <= 1'b0;
    end else begin
      r_div     <= w_div_nx;
      r_pclk_en <= (w_div_nx == DIV_LAST);
    end
  end

  always_ff @(posedge MCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_ph   <= '0;
      r_pv   <= '0;
      r_hblk <= 1'b0;
      r_vblk <= 1'b1;
      r_hsyn <= 1'b0;
      r_vsyn <= 1'b0;
      r_vfrm <= 1'b0;
      r_hofs <= '0;
      r_vofs <= '0;
    end else begin
      r_vfrm <= r_pclk_en & w_fstart;
      if (r_pclk_en) begin
        r_ph   <= w_ph_nx;
        r_pv   <= w_pv_nx;
        r_hblk <= (w_ph_nx >= H_ACT_B);
        r_vblk <= (w_pv_nx < VB_E_B) | (w_pv_nx >= VB_S_B);
        r_hsyn <= w_hs_in;
        r_vsyn <= w_vs_in;
        r_hofs <= w_hofs_nx;
        r_vofs <= w_vofs_nx;
      end
    end
  end

  assign PCLK_EN = r_pclk_en;
  assign PH      = r_ph;
  assign PV      = r_pv;
  assign HBLK    = r_hblk;
  assign VBLK    = r_vblk;
  assign HSYN    = r_hsyn;
  assign VSYN    = r_vsyn;
  assign VFRM    = r_vfrm;

endmodule

// File: tb/tb_gyruss_hvgen.sv
// Bench for gyruss_hvgen: default, wrapped-HSYN and shrunk
// timing instances checked against hand-computed values.
module tb_gyruss_hvgen;

  logic       MCLK = 1'b0;
  logic       RESET_N = 1'b0;
  logic [3:0] z4 = 4'd0;
  logic [3:0] hofs_s = 4'd0;
  logic [3:0] vofs_s = 4'd0;

  always #5 MCLK = ~MCLK;

  logic       d_pe, d_hb, d_vb, d_hs, d_vs, d_vf;
  logic [8:0] d_ph, d_pv;
  logic       w_pe, w_hb, w_vb, w_hs, w_vs, w_vf;
  logic [8:0] w_ph, w_pv;
  logic       s_pe, s_hb, s_vb, s_hs, s_vs, s_vf;
  logic [8:0] s_ph, s_pv;

  gyruss_hvgen u_dut (
    .MCLK(MCLK), .RESET_N(RESET_N), .HOFS(z4), .VOFS(z4),
    .PCLK_EN(d_pe), .PH(d_ph), .PV(d_pv), .HBLK(d_hb),
    .VBLK(d_vb), .HSYN(d_hs), .VSYN(d_vs), .VFRM(d_vf)
  );

  gyruss_hvgen #(.HS_START(370)) u_wr (
    .MCLK(MCLK), .RESET_N(RESET_N), .HOFS(z4), .VOFS(z4),
    .PCLK_EN(w_pe), .PH(w_ph), .PV(w_pv), .HBLK(w_hb),
    .VBLK(w_vb), .HSYN(w_hs), .VSYN(w_vs), .VFRM(w_vf)
  );

  gyruss_hvgen #(
    .CLK_DIV(2), .H_TOTAL(64), .H_ACTIVE(40),
    .HS_START(60), .HS_WIDTH(8), .V_TOTAL(40),
    .VB_END(4), .VB_START(34), .VS_START(36), .VS_WIDTH(3)
  ) u_sm (
    .MCLK(MCLK), .RESET_N(RESET_N), .HOFS(hofs_s), .VOFS(vofs_s),
    .PCLK_EN(s_pe), .PH(s_ph), .PV(s_pv), .HBLK(s_hb),
    .VBLK(s_vb), .HSYN(s_hs), .VSYN(s_vs), .VFRM(s_vf)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int n = 0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] wm(input int s, input int w,
                                     input int t);
    logic [63:0] m;
    m = '0;
    for (int i = 0; i < w; i++) m[(s + i) % t] = 1'b1;
    return m;
  endfunction

  typedef struct {
    int   e;
    int   ph;
    int   pv;
    logic pe;
    logic hb;
    logic vb;
    logic hs;
    logic hsw;
  } vec_t;

  vec_t tv[17];

  // One small-timing frame ending at MCLK (f+1)*5120.
  task automatic scan(input int f, input logic [3:0] nh,
                      input logic [3:0] nv, input int hs,
                      input int vs);
    logic [63:0] hm, hb, vm, bm;
    int vf_cnt, vf_pos, vs_bad, pvmax;
    logic prev;
    hm = '0; hb = '0; vm = '0; bm = '0;
    vf_cnt = 0; vf_pos = 0; vs_bad = 0; pvmax = 0;
    prev = s_vs;
    while (n < (f + 1) * 5120) begin
      @(posedge MCLK);
      n++;
      #1;
      if (n == f * 5120 + 2560) begin
        hofs_s = nh;
        vofs_s = nv;
      end
      if (s_vf) begin
        vf_cnt++;
        vf_pos = n;
      end
      if (n < (f + 1) * 5120) begin
        if (s_pv == 9'd30) begin
          hm[s_ph] = hm[s_ph] | s_hs;
          hb[s_ph] = hb[s_ph] | s_hb;
        end
        vm[s_pv] = vm[s_pv] | s_vs;
        bm[s_pv] = bm[s_pv] | s_vb;
        if (int'(s_pv) > pvmax) pvmax = int'(s_pv);
      end
      if (s_vs != prev && s_ph != 9'd0) vs_bad++;
      prev = s_vs;
    end
    chk($sformatf("f%0d hsyn", f), hm, wm(hs, 8, 64));
    chk($sformatf("f%0d vsyn", f), vm, wm(vs, 3, 40));
    chk($sformatf("f%0d hblk", f), hb, wm(40, 24, 64));
    chk($sformatf("f%0d vblk", f), bm, wm(34, 10, 40));
    chk($sformatf("f%0d vs_mid", f), 64'(vs_bad), 64'd0);
    chk($sformatf("f%0d pvmax", f), 64'(pvmax), 64'd39);
    chk($sformatf("f%0d vfrm_n", f), 64'(vf_cnt), 64'd1);
    chk($sformatf("f%0d vfrm_at", f), 64'(vf_pos),
        64'((f + 1) * 5120));
  endtask

  initial begin
    tv[0]  = '{0,    0,   0, 0, 0, 1, 0, 0};
    tv[1]  = '{7,    0,   0, 1, 0, 1, 0, 0};
    tv[2]  = '{8,    1,   0, 0, 0, 1, 0, 1};
    tv[3]  = '{15,   1,   0, 1, 0, 1, 0, 1};
    tv[4]  = '{16,   2,   0, 0, 0, 1, 0, 1};
    tv[5]  = '{2047, 255, 0, 1, 0, 1, 0, 0};
    tv[6]  = '{2048, 256, 0, 0, 1, 1, 0, 0};
    tv[7]  = '{2367, 295, 0, 1, 1, 1, 0, 0};
    tv[8]  = '{2368, 296, 0, 0, 1, 1, 1, 0};
    tv[9]  = '{2623, 327, 0, 1, 1, 1, 1, 0};
    tv[10] = '{2624, 328, 0, 0, 1, 1, 0, 0};
    tv[11] = '{2959, 369, 0, 1, 1, 1, 0, 0};
    tv[12] = '{2960, 370, 0, 0, 1, 1, 0, 1};
    tv[13] = '{3071, 383, 0, 1, 1, 1, 0, 1};
    tv[14] = '{3072, 0,   1, 0, 0, 1, 0, 1};
    tv[15] = '{3208, 17,  1, 0, 0, 1, 0, 1};
    tv[16] = '{3216, 18,  1, 0, 0, 1, 0, 0};

    #22;
    RESET_N = 1'b1;
    n = 0;
    for (int i = 0; i < 17; i++) begin
      while (n < tv[i].e) begin
        @(posedge MCLK);
        n++;
      end
      #1;
      chk($sformatf("e%0d ph", tv[i].e), 64'(d_ph), 64'(tv[i].ph));
      chk($sformatf("e%0d pv", tv[i].e), 64'(d_pv), 64'(tv[i].pv));
      chk($sformatf("e%0d pclk", tv[i].e), 64'(d_pe), 64'(tv[i].pe));
      chk($sformatf("e%0d hblk", tv[i].e), 64'(d_hb), 64'(tv[i].hb));
      chk($sformatf("e%0d vblk", tv[i].e), 64'(d_vb), 64'(tv[i].vb));
      chk($sformatf("e%0d hsyn", tv[i].e), 64'(d_hs), 64'(tv[i].hs));
      chk($sformatf("e%0d hsyn_w", tv[i].e), 64'(w_hs),
          64'(tv[i].hsw));
    end

    // Async reset in the middle of an HSYN pulse.
    while (n < 5475) begin
      @(posedge MCLK);
      n++;
    end
    #1;
    chk("pre ph", 64'(d_ph), 64'd300);
    chk("pre pv", 64'(d_pv), 64'd1);
    chk("pre hsyn", 64'(d_hs), 64'd1);
    #2;
    RESET_N = 1'b0;
    #1;
    chk("rst ph", 64'(d_ph), 64'd0);
    chk("rst pv", 64'(d_pv), 64'd0);
    chk("rst vblk", 64'(d_vb), 64'd1);
    chk("rst hblk", 64'(d_hb), 64'd0);
    chk("rst hsyn", 64'(d_hs), 64'd0);
    chk("rst pclk", 64'(d_pe), 64'd0);
    #1;
    RESET_N = 1'b1;
    n = 0;
    while (n < 7) begin
      @(posedge MCLK);
      n++;
    end
    #1;
    chk("rel e7 pclk", 64'(d_pe), 64'd1);
    chk("rel e7 ph", 64'(d_ph), 64'd0);
    @(posedge MCLK);
    n++;
    #1;
    chk("rel e8 pclk", 64'(d_pe), 64'd0);
    chk("rel e8 ph", 64'(d_ph), 64'd1);

    scan(0, 4'd7, 4'hE, 60, 36);
    scan(1, 4'h8, 4'd2, 3, 34);
    scan(2, 4'h8, 4'd2, 52, 38);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/gyruss_hvgen.md
Name: gyruss_hvgen

Overview:
- Video timing generator directly upstream of the Gyruss core.
- Divides MCLK into a single-cycle pixel-clock enable.
- Runs the 9-bit horizontal and vertical beam counters PH/PV that the core consumes.
- Produces blanking, sync and frame-start strobes for the scan converter, with sync positions adjustable for screen centring.

Parameters:
- CLK_DIV, 8: MCLK cycles per pixel (49.152 MHz to 6.144 MHz).
- H_TOTAL, 384: pixels per line.
- H_ACTIVE, 256: visible pixels; PH 0..H_ACTIVE-1 is visible.
- HS_START, 296: nominal HSYN assert pixel.
- HS_WIDTH, 32: HSYN length in pixels.
- V_TOTAL, 264: lines per frame.
- VB_END, 16: first visible line.
- VB_START, 240: first blanked line after the visible area.
- VS_START, 248: nominal VSYN assert line.
- VS_WIDTH, 3: VSYN length in lines.

Ports:
- MCLK  in  1  master clock.
- RESET_N  in  1  asynchronous active-low reset.
- HOFS  in  4  signed horizontal sync shift in pixels, -8..+7.
- VOFS  in  4  signed vertical sync shift in lines, -8..+7.
- PCLK_EN  out  1  one-MCLK-wide pixel strobe.
- PH  out  9  horizontal counter.
- PV  out  9  vertical counter.
- HBLK  out  1  horizontal blank.
- VBLK  out  1  vertical blank.
- HSYN  out  1  horizontal sync, active high.
- VSYN  out  1  vertical sync, active high.
- VFRM  out  1  frame-start pulse.

Behaviour:
- One clock domain, MCLK. Reset is asynchronous and active-low on RESET_N; every register clears immediately on assertion.
- Reset values:
  - PH=0, PV=0, divider=0, PCLK_EN=0.
  - HBLK=0, VBLK=1, HSYN=0, VSYN=0, VFRM=0.
  - Latched offsets = 0.
- Divider:
  - Counts 0..CLK_DIV-1 and wraps.
  - PCLK_EN=1 for exactly the MCLK cycle in which the divider equals CLK_DIV-1. After reset release the first strobe occurs on the CLK_DIV-th rising edge.
- Counter advance: on each MCLK edge with PCLK_EN=1, PH increments.
  - PH==H_TOTAL-1 wraps PH to 0 and advances PV.
  - PV==V_TOTAL-1 at line wrap returns PV to 0.
  - PH and PV never leave 0..TOTAL-1.
- Registered flags: HBLK, VBLK, HSYN, VSYN update on the same PCLK_EN edge as the counters and are decoded from the next counter values, so they are aligned with PH/PV with zero lag.
  - HBLK = (PH >= H_ACTIVE).
  - VBLK = (PV < VB_END) or (PV >= VB_START).
- Offsets:
  - HOFS/VOFS are sign-extended to 10 bits and sampled only on the PCLK_EN edge where PV wraps to 0 (frame start).
  - Mid-frame changes never tear the picture.
- Sync windows:
  - hs0 = HS_START + hofs_latched.
  - vs0 = VS_START + vofs_latched.
  - HSYN = 1 while PH is in hs0 .. hs0+HS_WIDTH-1. The window is computed mod H_TOTAL and may wrap past PH=H_TOTAL-1 into PH=0.
  - VSYN = 1 while PV is in vs0 .. vs0+VS_WIDTH-1, mod V_TOTAL. VSYN changes only at line starts (PH=0).
- VFRM:
  - One MCLK wide, asserted in the cycle after the PCLK_EN edge that sets PH=0, PV=0.
  - Exactly one VFRM per V_TOTAL*H_TOTAL*CLK_DIV MCLKs.
- Reset mid-frame: counters clear at once; the timing restarts from line 0 pixel 0 after release and no partial sync pulse persists.
- Arithmetic:
  - Counters are unsigned 9-bit; sync compares use 10-bit.
  - Wrap is done by conditional add/subtract of TOTAL, never by modulo hardware.

Decomposition:
- Shared package gyruss_vid_pkg:
  - The timing constants above, used as parameter defaults.
  - A 9-bit beam-position typedef shared with the core and the scan converter.
- One natural sub-module, gyruss_win_cmp: a wrap-aware window comparator (pos, start, width, total -> in-window).
  - Instantiated twice, for HSYN and VSYN.

Test Plan:
- Reset release, default parameters -> first PCLK_EN on MCLK edge 8, then every 8 cycles. PH counts 0..383 and wraps with PV 0->1 on the same edge.
- Run one full frame -> PV reaches 263, wraps to 0. VFRM pulses exactly once, 811008 MCLKs apart. VBLK is high for PV 0..15 and 240..263 only.
- HOFS=0 -> HSYN high for PH 296..327. HOFS=+7 -> HSYN high for PH 303..334. HOFS=-8 -> PH 288..319. Each takes effect only from the next frame.
- Parameters HS_START=370, HS_WIDTH=32 -> HSYN high for PH 370..383 and 0..17 with no gap at the wrap.
- Change VOFS from 0 to -2 at PV=100 -> current frame VSYN is lines 248..250; next frame VSYN is lines 246..248.
- Assert RESET_N low at PV=130, PH=200 -> PH=0, PV=0, VBLK=1, HSYN=0 immediately without a clock. After release, timing resumes from the first strobe at edge 8.
